// File: rtl/uart_program_loader.sv
// Program loader: assembles a UART byte stream (16-bit count, then LSB-first words)
// into instruction-memory writes and holds the CPU paused until a start pulse.
module uart_program_loader #(
   parameter int ADDR_W         = 8,
   parameter int MEM_DEPTH      = 256,
   parameter int TIMEOUT_CYCLES = 520800,
   parameter int TO_W           = 20
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic              start,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [15:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              load_led,
   output logic              load_done,
   output logic              load_err,
   output logic [15:0]       prog_len
);

   typedef enum logic [2:0] {CNT_LO, CNT_HI, INS_LO, INS_HI, DONE, RUN} state_t;

   localparam logic [16:0]     DEPTH_L = 17'(MEM_DEPTH);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_t            state, state_next;
   logic [7:0]        cnt_lo_q;
   logic [7:0]        ins_lo_q;
   logic [15:0]       idx;
   logic [TO_W-1:0]   to_cnt;
   logic [15:0]       count_rx;
   logic [15:0]       word_rx;
   logic [15:0]       idx_inc;
   logic              idx_in_mem;
   logic              timing;
   logic              timeout_hit;

   // A byte arriving in the expiry cycle suppresses the timeout.
   always_comb begin
      count_rx    = {rx_data, cnt_lo_q};
      word_rx     = {rx_data, ins_lo_q};
      idx_inc     = idx + 16'd1;
      idx_in_mem  = ({1'b0, idx} < DEPTH_L);
      timing      = (state == CNT_HI) || (state == INS_LO) || (state == INS_HI);
      timeout_hit = timing && !rx_valid && (to_cnt == TO_LAST);
      state_next  = state;
      load_led    = 1'b0;
      cpu_hold    = 1'b1;
      load_done   = 1'b0;
      case (state)
         CNT_LO: begin
            load_led = 1'b1;
            if (rx_valid) state_next = CNT_HI;
         end
         CNT_HI: begin
            load_led = 1'b1;
            if (rx_valid)         state_next = (count_rx == 16'd0) ? DONE : INS_LO;
            else if (timeout_hit) state_next = CNT_LO;
         end
         INS_LO: begin
            load_led = 1'b1;
            if (rx_valid)         state_next = INS_HI;
            else if (timeout_hit) state_next = CNT_LO;
         end
         INS_HI: begin
            load_led = 1'b1;
            if (rx_valid)         state_next = (idx_inc == prog_len) ? DONE : INS_LO;
            else if (timeout_hit) state_next = CNT_LO;
         end
         DONE: begin
            load_done = 1'b1;
            if (start) state_next = RUN;
         end
         RUN: begin
            cpu_hold  = 1'b0;
            load_done = 1'b1;
         end
         default: state_next = CNT_LO;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state <= CNT_LO;
      else        state <= state_next;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         load_err   <= 1'b0;
         prog_len   <= '0;
         cnt_lo_q   <= '0;
         ins_lo_q   <= '0;
         idx        <= '0;
         to_cnt     <= '0;
      end else begin
         imem_we <= 1'b0;
         if (!timing || rx_valid || (state_next != state)) to_cnt <= '0;
         else                                              to_cnt <= to_cnt + 1'b1;
         if (timeout_hit) begin
            load_err <= 1'b1;
            idx      <= '0;
         end
         if (rx_valid) begin
            case (state)
               CNT_LO: begin
                  cnt_lo_q <= rx_data;
                  load_err <= 1'b0;
                  idx      <= '0;
               end
               CNT_HI: begin
                  prog_len <= count_rx;
                  if ({1'b0, count_rx} > DEPTH_L) load_err <= 1'b1;
               end
               INS_LO: ins_lo_q <= rx_data;
               INS_HI: begin
                  // Words beyond the memory are consumed but never written.
                  if (idx_in_mem) begin
                     imem_we    <= 1'b1;
                     imem_addr  <= idx[ADDR_W-1:0];
                     imem_wdata <= word_rx;
                  end
                  idx <= idx_inc;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader: expected memory writes are queued by the
// stimulus from a word-level model and matched by a monitor on every write strobe.
module tb_uart_program_loader;

   localparam int MEM_DEPTH = 4;
   localparam int TIMEOUT   = 100;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        start = 1'b0;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [15:0] imem_wdata;
   logic        cpu_hold;
   logic        load_led;
   logic        load_done;
   logic        load_err;
   logic [15:0] prog_len;

   uart_program_loader #(
      .ADDR_W(8), .MEM_DEPTH(MEM_DEPTH), .TIMEOUT_CYCLES(TIMEOUT), .TO_W(7)
   ) dut (
      .CLK(CLK), .RESET(RESET), .rx_data(rx_data), .rx_valid(rx_valid), .start(start),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_hold(cpu_hold), .load_led(load_led), .load_done(load_done),
      .load_err(load_err), .prog_len(prog_len)
   );

   always #5 CLK = ~CLK;

   int unsigned cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct packed {
      logic [7:0]  a;
      logic [15:0] d;
      int unsigned c;
   } wr_t;

   wr_t         exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] wbuf[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the oldest expected write, in the expected cycle.
   always @(negedge CLK) begin
      wr_t e;
      if (RESET && imem_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                     imem_addr, imem_wdata);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(imem_addr), 32'(e.a));
            chk("wr_data", 32'(imem_wdata), 32'(e.d));
            chk("wr_cycle", cyc, e.c);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap, input bit wr,
                            input logic [7:0] a, input logic [15:0] d);
      wr_t e;
      repeat (gap) @(negedge CLK);
      @(negedge CLK);
      rx_data  = b;
      rx_valid = 1'b1;
      if (wr) begin
         e.a = a;
         e.d = d;
         e.c = cyc + 1;
         exp_q.push_back(e);
      end
      @(negedge CLK);
      rx_valid = 1'b0;
   endtask

   // Reference: count, then each word LSB first; word i lands at address i while i < MEM_DEPTH.
   task automatic load(input int cnt, input int max_gap);
      logic [15:0] c16;
      c16 = 16'(cnt);
      send_byte(c16[7:0], $urandom_range(max_gap, 0), 1'b0, 8'h00, 16'h0000);
      send_byte(c16[15:8], $urandom_range(max_gap, 0), 1'b0, 8'h00, 16'h0000);
      for (int i = 0; i < cnt; i++) begin
         send_byte(wbuf[i][7:0], $urandom_range(max_gap, 0), 1'b0, 8'h00, 16'h0000);
         send_byte(wbuf[i][15:8], $urandom_range(max_gap, 0), (i < MEM_DEPTH),
                   8'(i), wbuf[i]);
      end
   endtask

   task automatic check_done(input int cnt);
      @(negedge CLK);
      chk("queue_drained", exp_q.size(), 0);
      chk("prog_len", 32'(prog_len), 32'(cnt));
      chk("load_done", 32'(load_done), 32'd1);
      chk("load_led_done", 32'(load_led), 32'd0);
      chk("cpu_hold_done", 32'(cpu_hold), 32'd1);
      chk("load_err_done", 32'(load_err), (cnt > MEM_DEPTH) ? 32'd1 : 32'd0);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET = 1'b0;
      repeat (2) @(negedge CLK);
      RESET = 1'b1;
      chk("rst_led", 32'(load_led), 32'd1);
      chk("rst_prog_len", 32'(prog_len), 32'd0);
   endtask

   task automatic pulse_start();
      @(negedge CLK);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_we"}, 32'(imem_we), 32'd0);
      chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
      chk({tag, "_wdata"}, 32'(imem_wdata), 32'd0);
      chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
      chk({tag, "_led"}, 32'(load_led), 32'd1);
      chk({tag, "_done"}, 32'(load_done), 32'd0);
      chk({tag, "_err"}, 32'(load_err), 32'd0);
      chk({tag, "_len"}, 32'(prog_len), 32'd0);
   endtask

   initial begin
      int cnt;
      #1 RESET = 1'b0;
      #1 chk_reset_outputs("reset");
      repeat (2) @(negedge CLK);
      RESET = 1'b1;

      // Three-word program from the example image, then release the CPU.
      wbuf[0] = 16'h0513; wbuf[1] = 16'h0093; wbuf[2] = 16'h0067;
      load(3, 0);
      check_done(3);
      pulse_start();
      chk("run_hold", 32'(cpu_hold), 32'd0);
      chk("run_done", 32'(load_done), 32'd1);
      chk("run_led", 32'(load_led), 32'd0);

      // Empty program.
      do_reset();
      load(0, 2);
      check_done(0);

      // Overflow: five words into a four-slot memory.
      do_reset();
      for (int i = 0; i < 5; i++) wbuf[i] = 16'($urandom);
      load(5, 1);
      check_done(5);

      // Timeout after one byte of the first word.
      do_reset();
      send_byte(8'h02, 0, 1'b0, 8'h00, 16'h0000);
      send_byte(8'h00, 0, 1'b0, 8'h00, 16'h0000);
      send_byte(8'hAA, 0, 1'b0, 8'h00, 16'h0000);
      repeat (TIMEOUT - 1) @(negedge CLK);
      chk("to_not_yet_err", 32'(load_err), 32'd0);
      @(negedge CLK);
      chk("to_err", 32'(load_err), 32'd1);
      chk("to_led", 32'(load_led), 32'd1);
      chk("to_done", 32'(load_done), 32'd0);
      chk("to_prog_len_kept", 32'(prog_len), 32'd2);
      send_byte(8'h01, 3, 1'b0, 8'h00, 16'h0000);
      chk("to_err_cleared", 32'(load_err), 32'd0);
      send_byte(8'h00, 0, 1'b0, 8'h00, 16'h0000);
      send_byte(8'hCD, 0, 1'b0, 8'h00, 16'h0000);
      send_byte(8'hAB, 0, 1'b1, 8'h00, 16'hABCD);
      check_done(1);

      // Bytes landing exactly in the expiry cycle are accepted.
      do_reset();
      send_byte(8'h01, 0, 1'b0, 8'h00, 16'h0000);
      send_byte(8'h00, TIMEOUT - 2, 1'b0, 8'h00, 16'h0000);
      send_byte(8'h34, TIMEOUT - 2, 1'b0, 8'h00, 16'h0000);
      send_byte(8'h12, TIMEOUT - 2, 1'b1, 8'h00, 16'h1234);
      check_done(1);

      // Start ignored mid-load; byte ignored in DONE; start wins over byte in DONE.
      do_reset();
      wbuf[0] = 16'hBEEF; wbuf[1] = 16'h0F0F;
      send_byte(8'h02, 0, 1'b0, 8'h00, 16'h0000);
      send_byte(8'h00, 0, 1'b0, 8'h00, 16'h0000);
      pulse_start();
      chk("ins_lo_start_hold", 32'(cpu_hold), 32'd1);
      chk("ins_lo_start_led", 32'(load_led), 32'd1);
      send_byte(8'hEF, 0, 1'b0, 8'h00, 16'h0000);
      send_byte(8'hBE, 0, 1'b1, 8'h00, 16'hBEEF);
      send_byte(8'h0F, 0, 1'b0, 8'h00, 16'h0000);
      send_byte(8'h0F, 0, 1'b1, 8'h01, 16'h0F0F);
      check_done(2);
      send_byte(8'h55, 0, 1'b0, 8'h00, 16'h0000);
      chk("done_rx_ignored", 32'(load_done), 32'd1);
      chk("done_rx_hold", 32'(cpu_hold), 32'd1);
      @(negedge CLK);
      start    = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h77;
      @(negedge CLK);
      start    = 1'b0;
      rx_valid = 1'b0;
      chk("start_rx_hold", 32'(cpu_hold), 32'd0);
      chk("start_rx_done", 32'(load_done), 32'd1);

      // Asynchronous reset after the first of two words, then a fresh load.
      do_reset();
      send_byte(8'h02, 0, 1'b0, 8'h00, 16'h0000);
      send_byte(8'h00, 0, 1'b0, 8'h00, 16'h0000);
      send_byte(8'h11, 0, 1'b0, 8'h00, 16'h0000);
      send_byte(8'h22, 0, 1'b1, 8'h00, 16'h2211);
      @(negedge CLK);
      @(posedge CLK);
      #2 RESET = 1'b0;
      #1 chk_reset_outputs("async");
      repeat (2) @(negedge CLK);
      RESET = 1'b1;
      send_byte(8'h01, 0, 1'b0, 8'h00, 16'h0000);
      send_byte(8'h00, 0, 1'b0, 8'h00, 16'h0000);
      send_byte(8'h34, 0, 1'b0, 8'h00, 16'h0000);
      send_byte(8'h12, 0, 1'b1, 8'h00, 16'h1234);
      check_done(1);

      // Randomized images with random inter-byte gaps.
      for (int n = 0; n < 8; n++) begin
         do_reset();
         cnt = $urandom_range(6, 0);
         for (int i = 0; i < cnt; i++) wbuf[i] = 16'($urandom);
         load(cnt, 4);
         check_done(cnt);
         if ($urandom_range(1, 0) == 1) begin
            pulse_start();
            chk("rand_run_hold", 32'(cpu_hold), 32'd0);
         end
      end

      repeat (3) @(negedge CLK);
      chk("final_queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
